// File: rtl/dma_ctrl_pkg.sv
// Shared definitions for the DMA descriptor scheduler: controller states,
// default widths and the default WAIT supervision limit.
package dma_ctrl_pkg;

   localparam int unsigned DEF_ADDR_W         = 32;
   localparam int unsigned DEF_LEN_W          = 16;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      RELEASE = 3'd3,
      HALT    = 3'd4
   } dma_state_e;

   // States in which a transfer is being launched, run or retired.
   function automatic logic is_busy_state(input dma_state_e st);
      return (st == ISSUE) || (st == WAIT) || (st == RELEASE);
   endfunction

endpackage

// File: rtl/dma_desc_scheduler_fifo.sv
// Synchronous descriptor FIFO with occupancy count and a single-cycle flush.
// The head entry is presented combinationally on rd_data.
module desc_fifo #(
   parameter int unsigned WIDTH = 48,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

   // Storage array: written at the tail on every accepted push.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_r[i] <= {WIDTH{1'b0}};
         end
      end else if (push) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush empties the queue outright.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else if (flush) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + PTR_W'(1);
         end
         case ({push, pop})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

endmodule

// File: rtl/dma_desc_scheduler.sv
// Descriptor-driven sequencer for axis_dma_write: queues (addr, len) pairs,
// issues them one at a time, supervises each transfer with a timeout and
// reports completions, interrupts and a sticky timeout error.
module dma_desc_scheduler
   import dma_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W         = DEF_ADDR_W,
   parameter int unsigned LEN_W          = DEF_LEN_W,
   parameter int unsigned DEPTH          = 4,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    enable,
   input  logic                    abort,
   input  logic                    err_clr,
   input  logic                    desc_valid,
   output logic                    desc_ready,
   input  logic [ADDR_W-1:0]       desc_addr,
   input  logic [LEN_W-1:0]        desc_len,
   output logic                    dma_start,
   output logic [ADDR_W-1:0]       dma_base_addr,
   output logic [LEN_W-1:0]        dma_length,
   input  logic                    dma_done,
   output logic                    busy,
   output logic [$clog2(DEPTH):0]  fifo_count,
   output logic [15:0]             done_count,
   output logic                    irq,
   output logic                    err_timeout
);

   localparam int unsigned      CNT_W    = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(DEPTH);
   localparam logic [31:0]      TO_LAST  = 32'(TIMEOUT_CYCLES) - 32'd1;
   localparam bit               TO_EN    = (TIMEOUT_CYCLES != 0);

   dma_state_e          state_r;
   dma_state_e          state_s;
   logic [CNT_W-1:0]    count_s;
   logic [ADDR_W-1:0]   head_addr_s;
   logic [LEN_W-1:0]    head_len_s;
   logic                push_s;
   logic                pop_s;
   logic                load_s;
   logic                start_s;
   logic                complete_s;
   logic                timeout_s;
   logic [31:0]         wait_cnt_r;

   logic                dma_start_r;
   logic [ADDR_W-1:0]   base_addr_r;
   logic [LEN_W-1:0]    length_r;
   logic                busy_r;
   logic [15:0]         done_count_r;
   logic                irq_r;
   logic                err_timeout_r;

   // Acceptance depends only on registered occupancy and abort, never on dma_done.
   assign desc_ready = (count_s < FULL_LVL) & ~abort;
   assign push_s     = desc_valid & desc_ready;

   desc_fifo #(
      .WIDTH (ADDR_W + LEN_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (abort),
      .push    (push_s),
      .wr_data ({desc_addr, desc_len}),
      .pop     (pop_s),
      .rd_data ({head_addr_s, head_len_s}),
      .count   (count_s)
   );

   // Controller state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state and per-cycle action decode; abort blocks a pop in the same cycle.
   always_comb begin
      state_s    = state_r;
      pop_s      = 1'b0;
      load_s     = 1'b0;
      start_s    = 1'b0;
      complete_s = 1'b0;
      timeout_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (enable && (count_s != {CNT_W{1'b0}}) && !abort) begin
               pop_s = 1'b1;
               if (head_len_s == {LEN_W{1'b0}}) begin
                  complete_s = 1'b1;
                  state_s    = IDLE;
               end else begin
                  load_s  = 1'b1;
                  state_s = ISSUE;
               end
            end else begin
               state_s = IDLE;
            end
         end
         ISSUE: begin
            start_s = 1'b1;
            state_s = WAIT;
         end
         WAIT: begin
            if (dma_done) begin
               complete_s = 1'b1;
               state_s    = RELEASE;
            end else if (TO_EN && (wait_cnt_r == TO_LAST)) begin
               timeout_s = 1'b1;
               state_s   = HALT;
            end else begin
               state_s = WAIT;
            end
         end
         RELEASE: begin
            if (!dma_done) begin
               state_s = IDLE;
            end else begin
               state_s = RELEASE;
            end
         end
         HALT: begin
            if (err_clr) begin
               state_s = RELEASE;
            end else begin
               state_s = HALT;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Cycles spent in WAIT; restarts from zero on every WAIT entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wait_cnt_r <= 32'd0;
      end else if (state_r == WAIT) begin
         wait_cnt_r <= wait_cnt_r + 32'd1;
      end else begin
         wait_cnt_r <= 32'd0;
      end
   end

   // Registered DMA command, status and error outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dma_start_r   <= 1'b0;
         base_addr_r   <= {ADDR_W{1'b0}};
         length_r      <= {LEN_W{1'b0}};
         busy_r        <= 1'b0;
         done_count_r  <= 16'd0;
         irq_r         <= 1'b0;
         err_timeout_r <= 1'b0;
      end else begin
         dma_start_r <= start_s;
         if (load_s) begin
            base_addr_r <= head_addr_s;
            length_r    <= head_len_s;
         end
         busy_r <= is_busy_state(state_s);
         if (complete_s) begin
            done_count_r <= done_count_r + 16'd1;
         end
         irq_r <= complete_s;
         if (timeout_s) begin
            err_timeout_r <= 1'b1;
         end else if (err_clr) begin
            err_timeout_r <= 1'b0;
         end
      end
   end

   assign dma_start     = dma_start_r;
   assign dma_base_addr = base_addr_r;
   assign dma_length    = length_r;
   assign busy          = busy_r;
   assign fifo_count    = count_s;
   assign done_count    = done_count_r;
   assign irq           = irq_r;
   assign err_timeout   = err_timeout_r;

endmodule
